bpfcap: RTL and testbench

- Packet-capture copy engine for the BPF capture path.
- Software programs a source word window `[pkt_begin, pkt_end)` and a destination base through an Avalon-MM CSR slave (s0), then sets GO.
- The block reads the window word-by-word through read master m0 and writes each word through write master m1.
- It sits between the HPS/NIOS CSR bus and the packet memory / capture buffer.

---
 rtl/bpfcap_pkg.sv | 27 ++
 rtl/bpfcap_csr.sv | 108 ++++++++++
 rtl/bpfcap.sv | 169 ++++++++++++++++
 tb/tb_bpfcap.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpfcap_pkg.sv
// rtl/bpfcap_pkg.sv - shared constants, CSR map and FSM states for the bpfcap copy engine
package bpfcap_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 16;

    localparam logic [2:0] CSR_CONTROL     = 3'd0;
    localparam logic [2:0] CSR_PKT_BEGIN   = 3'd1;
    localparam logic [2:0] CSR_PKT_END     = 3'd2;
    localparam logic [2:0] CSR_DST_ADDR    = 3'd3;
    localparam logic [2:0] CSR_WORD_COUNT  = 3'd4;
    localparam logic [2:0] CSR_FILTER_VAL  = 3'd5;
    localparam logic [2:0] CSR_FILTER_MASK = 3'd6;

    localparam int CTRL_GO    = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_MATCH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bpfcap_csr.sv
// rtl/bpfcap_csr.sv - s0 register file, GO/DONE-clear strobes and registered readback (filter regs under BPFCAP_FILTER_EN)
module bpfcap_csr
    import bpfcap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_s0_address,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    input  logic              avs_s0_read,
    output logic [DATA_W-1:0] avs_s0_readdata,
`ifdef BPFCAP_FILTER_EN
    input  logic              match_i,
    output logic [DATA_W-1:0] filter_val_o,
    output logic [DATA_W-1:0] filter_mask_o,
`endif
    input  logic              busy_i,
    input  logic              done_i,
    input  logic [DATA_W-1:0] word_count_i,
    output logic              go_o,
    output logic              done_clr_o,
    output logic [ADDR_W-1:0] pkt_begin_o,
    output logic [ADDR_W-1:0] pkt_end_o,
    output logic [ADDR_W-1:0] dst_addr_o
);

    logic [DATA_W-1:0] readdata_q;
    logic [ADDR_W-1:0] pkt_begin_q;
    logic [ADDR_W-1:0] pkt_end_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [DATA_W-1:0] rd_mux;
    logic              ctrl_wr;
`ifdef BPFCAP_FILTER_EN
    logic [DATA_W-1:0] filter_val_q;
    logic [DATA_W-1:0] filter_mask_q;
    logic              match_bit;
    assign match_bit     = match_i;
    assign filter_val_o  = filter_val_q;
    assign filter_mask_o = filter_mask_q;
`else
    logic              match_bit;
    assign match_bit = 1'b0;
`endif

    assign ctrl_wr     = avs_s0_write && (avs_s0_address == CSR_CONTROL);
    assign go_o        = ctrl_wr && avs_s0_writedata[CTRL_GO] && !busy_i;
    assign done_clr_o  = ctrl_wr && avs_s0_writedata[CTRL_DONE];
    assign pkt_begin_o = pkt_begin_q;
    assign pkt_end_o   = pkt_end_q;
    assign dst_addr_o  = dst_addr_q;
    assign avs_s0_readdata = readdata_q;

    // Readback mux; GO always reads 0, reserved addresses read 0
    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            CSR_CONTROL: begin
                rd_mux[CTRL_BUSY]  = busy_i;
                rd_mux[CTRL_DONE]  = done_i;
                rd_mux[CTRL_MATCH] = match_bit;
            end
            CSR_PKT_BEGIN:  rd_mux = pkt_begin_q;
            CSR_PKT_END:    rd_mux = pkt_end_q;
            CSR_DST_ADDR:   rd_mux = dst_addr_q;
            CSR_WORD_COUNT: rd_mux = word_count_i;
`ifdef BPFCAP_FILTER_EN
            CSR_FILTER_VAL:  rd_mux = filter_val_q;
            CSR_FILTER_MASK: rd_mux = filter_mask_q;
`endif
            default:        rd_mux = '0;
        endcase
    end

    // Register writes (window/destination frozen while a run is active) and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q  <= '0;
            pkt_begin_q <= '0;
            pkt_end_q   <= '0;
            dst_addr_q  <= '0;
`ifdef BPFCAP_FILTER_EN
            filter_val_q  <= '0;
            filter_mask_q <= '0;
`endif
        end else begin
            if (avs_s0_read) begin
                readdata_q <= rd_mux;
            end
            if (avs_s0_write && !busy_i) begin
                case (avs_s0_address)
                    CSR_PKT_BEGIN: pkt_begin_q <= avs_s0_writedata;
                    CSR_PKT_END:   pkt_end_q   <= avs_s0_writedata;
                    CSR_DST_ADDR:  dst_addr_q  <= avs_s0_writedata;
                    default: ;
                endcase
            end
`ifdef BPFCAP_FILTER_EN
            if (avs_s0_write && (avs_s0_address == CSR_FILTER_VAL)) begin
                filter_val_q <= avs_s0_writedata;
            end
            if (avs_s0_write && (avs_s0_address == CSR_FILTER_MASK)) begin
                filter_mask_q <= avs_s0_writedata;
            end
`endif
        end
    end

endmodule

// File: rtl/bpfcap.sv
// rtl/bpfcap.sv - BPF capture copy engine top: run FSM, m0 read / m1 write datapath (filter under BPFCAP_FILTER_EN)
module bpfcap
    import bpfcap_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         avs_s0_address,
    input  logic               avs_s0_write,
    input  logic [DATA_W-1:0]  avs_s0_writedata,
    input  logic               avs_s0_read,
    output logic [DATA_W-1:0]  avs_s0_readdata,
    output logic [ADDR_W-1:0]  avs_m0_address,
    output logic               avs_m0_read,
    output logic [BURST_W-1:0] avs_m0_burstcount,
    input  logic [DATA_W-1:0]  avs_m0_readdata,
    output logic [ADDR_W-1:0]  avs_m1_address,
    output logic               avs_m1_write,
    output logic [DATA_W-1:0]  avs_m1_writedata,
    output logic [BURST_W-1:0] avs_m1_burstcount
);

    state_e            state_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              m0_read_q;
    logic [ADDR_W-1:0] remaining_q;
    logic              rd_pending_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              m1_write_q;
    logic [ADDR_W-1:0] m1_addr_q;
    logic [DATA_W-1:0] m1_data_q;
    logic              done_q;
    logic [DATA_W-1:0] word_count_q;

    logic              go;
    logic              done_clr;
    logic              busy;
    logic              pass;
    logic [ADDR_W-1:0] pkt_begin;
    logic [ADDR_W-1:0] pkt_end;
    logic [ADDR_W-1:0] dst_addr;

    assign busy = (state_q != ST_IDLE);

`ifdef BPFCAP_FILTER_EN
    logic              first_q;
    logic              match_q;
    logic              match_now;
    logic [DATA_W-1:0] filter_val;
    logic [DATA_W-1:0] filter_mask;
    // The first word of a run decides whether the whole run is written out
    assign match_now = ((avs_m0_readdata & filter_mask) == filter_val);
    assign pass      = first_q ? match_now : match_q;
`else
    assign pass = 1'b1;
`endif

    bpfcap_csr u_csr (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
`ifdef BPFCAP_FILTER_EN
        .match_i          (match_q),
        .filter_val_o     (filter_val),
        .filter_mask_o    (filter_mask),
`endif
        .busy_i           (busy),
        .done_i           (done_q),
        .word_count_i     (word_count_q),
        .go_o             (go),
        .done_clr_o       (done_clr),
        .pkt_begin_o      (pkt_begin),
        .pkt_end_o        (pkt_end),
        .dst_addr_o       (dst_addr)
    );

    assign avs_m0_address    = rd_ptr_q;
    assign avs_m0_read       = m0_read_q;
    assign avs_m0_burstcount = BURST_W'(1);
    assign avs_m1_address    = m1_addr_q;
    assign avs_m1_write      = m1_write_q;
    assign avs_m1_writedata  = m1_data_q;
    assign avs_m1_burstcount = BURST_W'(1);

    // Run FSM plus read-to-write pipeline: read in k, data captured end of k+1, write in k+2
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            m0_read_q    <= 1'b0;
            remaining_q  <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            m1_write_q   <= 1'b0;
            m1_addr_q    <= '0;
            m1_data_q    <= '0;
            done_q       <= 1'b0;
            word_count_q <= '0;
`ifdef BPFCAP_FILTER_EN
            first_q      <= 1'b0;
            match_q      <= 1'b0;
`endif
        end else begin
            rd_pending_q <= m0_read_q;
            m1_write_q   <= 1'b0;
            if (done_clr) begin
                done_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        word_count_q <= '0;
                        if (pkt_end > pkt_begin) begin
                            done_q      <= 1'b0;
                            state_q     <= ST_RUN;
                            m0_read_q   <= 1'b1;
                            rd_ptr_q    <= pkt_begin;
                            remaining_q <= pkt_end - pkt_begin;
                            wr_ptr_q    <= dst_addr;
`ifdef BPFCAP_FILTER_EN
                            first_q     <= 1'b1;
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (remaining_q == ADDR_W'(1)) begin
                        m0_read_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                    end
                    remaining_q <= remaining_q - ADDR_W'(1);
                end
                ST_DRAIN: begin
                    // The cycle with no capture pending is the one issuing the final write
                    if (!rd_pending_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (rd_pending_q) begin
`ifdef BPFCAP_FILTER_EN
                first_q <= 1'b0;
                if (first_q) begin
                    match_q <= match_now;
                end
`endif
                if (pass) begin
                    m1_write_q   <= 1'b1;
                    m1_addr_q    <= wr_ptr_q;
                    m1_data_q    <= avs_m0_readdata;
                    wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                    word_count_q <= word_count_q + DATA_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpfcap.sv
// tb/tb_bpfcap.sv - scoreboard bench for bpfcap: CSR access, copy runs, empty window, busy guards, mid-run reset
module tb_bpfcap;

    logic        clk;
    logic        reset;
    logic [2:0]  avs_s0_address;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;
    logic [31:0] avs_m0_address;
    logic        avs_m0_read;
    logic [15:0] avs_m0_burstcount;
    logic [31:0] avs_m0_readdata;
    logic [31:0] avs_m1_address;
    logic        avs_m1_write;
    logic [31:0] avs_m1_writedata;
    logic [15:0] avs_m1_burstcount;

    bpfcap dut (
        .clk               (clk),
        .reset             (reset),
        .avs_s0_address    (avs_s0_address),
        .avs_s0_write      (avs_s0_write),
        .avs_s0_writedata  (avs_s0_writedata),
        .avs_s0_read       (avs_s0_read),
        .avs_s0_readdata   (avs_s0_readdata),
        .avs_m0_address    (avs_m0_address),
        .avs_m0_read       (avs_m0_read),
        .avs_m0_burstcount (avs_m0_burstcount),
        .avs_m0_readdata   (avs_m0_readdata),
        .avs_m1_address    (avs_m1_address),
        .avs_m1_write      (avs_m1_write),
        .avs_m1_writedata  (avs_m1_writedata),
        .avs_m1_burstcount (avs_m1_burstcount)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t rdq[$];
    exp_t wrq[$];
    int   total;
    int   bad;
    int   cyc;
    int   wr_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a - 32'h16;
    endfunction

    // Source memory, fixed read latency of one cycle
    always @(posedge clk) begin
        avs_m0_readdata <= avs_m0_read ? mem_f(avs_m0_address) : 32'hdead_beef;
    end

    // Bus monitor: every strobe must match the next scoreboard entry in address, data and cycle
    always @(negedge clk) begin
        exp_t e;
        if (avs_m0_read === 1'b1) begin
            total++;
            if (rdq.size() == 0) begin
                bad++;
                $display("FAIL m0_unexpected: read addr=%h cyc=%0d, required no read", avs_m0_address, cyc);
            end else begin
                e = rdq.pop_front();
                if (avs_m0_address !== e.addr || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL m0_read: addr=%h cyc=%0d, required addr=%h cyc=%0d",
                             avs_m0_address, cyc, e.addr, e.cyc);
                end
            end
        end
        if (avs_m1_write === 1'b1) begin
            total++;
            wr_seen++;
            if (wrq.size() == 0) begin
                bad++;
                $display("FAIL m1_unexpected: write addr=%h data=%h cyc=%0d, required no write",
                         avs_m1_address, avs_m1_writedata, cyc);
            end else begin
                e = wrq.pop_front();
                if (avs_m1_address !== e.addr || avs_m1_writedata !== e.data || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL m1_write: addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             avs_m1_address, avs_m1_writedata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_s0_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_s0_read = 1'b0;
        d = avs_s0_readdata;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        cpu_read(a, v);
        total++;
        if (v !== exp) begin
            bad++;
            $display("FAIL %s: read %h, required %h", name, v, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] dst);
        int go_cyc;
        cpu_write(3'd1, b);
        cpu_write(3'd2, e);
        cpu_write(3'd3, dst);
        go_cyc = cyc;
        for (int i = 0; i < int'(e - b); i++) begin
            rdq.push_back('{addr: b + 32'(i), data: 32'h0, cyc: go_cyc + 1 + i});
            wrq.push_back('{addr: dst + 32'(i), data: mem_f(b + 32'(i)), cyc: go_cyc + 3 + i});
        end
        cpu_write(3'd0, 32'h1);
    endtask

    task automatic wait_done();
        logic [31:0] v;
        v = '0;
        for (int n = 0; n < 100; n++) begin
            cpu_read(3'd0, v);
            if (v[2]) break;
        end
        total++;
        if (v !== 32'h4) begin
            bad++;
            $display("FAIL done_wait: CONTROL=%h, required 00000004", v);
        end
        total++;
        if (rdq.size() != 0 || wrq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending reads=%0d writes=%0d, required 0/0", rdq.size(), wrq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (avs_m0_read !== 1'b0 || avs_m1_write !== 1'b0 || avs_s0_readdata !== 32'h0 ||
            avs_m0_address !== 32'h0 || avs_m1_address !== 32'h0 || avs_m1_writedata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: m0_read=%b m1_write=%b rdata=%h m0a=%h m1a=%h m1d=%h, required all 0",
                     avs_m0_read, avs_m1_write, avs_s0_readdata, avs_m0_address, avs_m1_address, avs_m1_writedata);
        end
        total++;
        if (avs_m0_burstcount !== 16'd1 || avs_m1_burstcount !== 16'd1) begin
            bad++;
            $display("FAIL reset_burst: m0=%0d m1=%0d, required 1/1", avs_m0_burstcount, avs_m1_burstcount);
        end
        check_reg("reset_control", 3'd0, 32'h0);
        check_reg("reset_count", 3'd4, 32'h0);
    endtask

    task automatic test_csr_rw();
        cpu_write(3'd0, 32'h0);
        cpu_write(3'd1, 32'h20);
        cpu_write(3'd2, 32'h28);
        check_reg("pkt_begin_rb", 3'd1, 32'h20);
        check_reg("pkt_end_rb", 3'd2, 32'h28);
        cpu_write(3'd7, 32'hffff_ffff);
        check_reg("reserved7", 3'd7, 32'h0);
`ifndef BPFCAP_FILTER_EN
        cpu_write(3'd5, 32'h1234_5678);
        check_reg("reserved5", 3'd5, 32'h0);
`endif
        check_reg("idle_control", 3'd0, 32'h0);
    endtask

    task automatic test_copy();
        start_run(32'h20, 32'h28, 32'h100);
        wait_done();
        check_reg("copy_count", 3'd4, 32'd8);
    endtask

    task automatic test_empty();
        cpu_write(3'd0, 32'h4);
        check_reg("done_w1c", 3'd0, 32'h0);
        cpu_write(3'd1, 32'h20);
        cpu_write(3'd2, 32'h20);
        cpu_write(3'd0, 32'h1);
        check_reg("empty_done", 3'd0, 32'h4);
        check_reg("empty_count", 3'd4, 32'h0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        start_run(32'h20, 32'h28, 32'h200);
        cpu_write(3'd0, 32'h1);
        cpu_write(3'd1, 32'h50);
        cpu_write(3'd2, 32'h60);
        wait_done();
        check_reg("busy_begin_kept", 3'd1, 32'h20);
        check_reg("busy_end_kept", 3'd2, 32'h28);
        check_reg("busy_count", 3'd4, 32'd8);
    endtask

    task automatic test_reset_midrun();
        wr_seen = 0;
        start_run(32'h40, 32'h48, 32'h300);
        for (int i = 0; i < 50 && wr_seen < 3; i++) @(posedge clk);
        #1;
        total++;
        if (wr_seen < 3) begin
            bad++;
            $display("FAIL midrun_wait: writes seen=%0d, required 3", wr_seen);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        rdq.delete();
        wrq.delete();
        total++;
        if (avs_m0_read !== 1'b0 || avs_m1_write !== 1'b0) begin
            bad++;
            $display("FAIL midrun_strobes: m0_read=%b m1_write=%b, required 0/0", avs_m0_read, avs_m1_write);
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (wr_seen !== 4) begin
            bad++;
            $display("FAIL midrun_writes: writes seen=%0d, required 4", wr_seen);
        end
        check_reg("midrun_control", 3'd0, 32'h0);
        check_reg("midrun_count", 3'd4, 32'h0);
        check_reg("midrun_begin", 3'd1, 32'h0);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        cyc              = 0;
        wr_seen          = 0;
        reset            = 1'b1;
        avs_s0_address   = 3'd0;
        avs_s0_write     = 1'b0;
        avs_s0_writedata = 32'h0;
        avs_s0_read      = 1'b0;
        test_reset();
        test_csr_rw();
        test_copy();
        test_empty();
        test_busy_ignore();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
